fft_bitrev: RTL

FFT_BITREV -- requirements
Module: fft_bitrev

---
 rtl/fft_bitrev_if.sv | 13 +
 rtl/fft_bitrev.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fft_bitrev_if.sv
// Sample stream bundle for fft_bitrev: bit-reversed input side and natural-order output side.
interface fft_bitrev_if #(
    parameter int DBW = 3
);
    logic               din_valid;
    logic [2*DBW-1:0]   din;
    logic               dout_valid;
    logic [2*DBW-1:0]   dout;
    logic               dout_first;

    modport slave  (input  din_valid, din, output dout_valid, dout, dout_first);
    modport master (output din_valid, din, input  dout_valid, dout, dout_first);
endinterface

// File: rtl/fft_bitrev.sv
// Ping-pong reorder buffer turning bit-reversed FFT output into natural bin order.
// Define FFT_BITREV_CONJ_EN to emit the complex conjugate (saturating imag negation).
module fft_bitrev #(
    parameter int DBW = 3,
    parameter int CBW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    fft_bitrev_if.slave   bus
);
    localparam int N  = 1 << CBW;
    localparam int SW = 2 * DBW;

    typedef enum logic {IDLE, READ} state_t;

    state_t          state_q, state_d;
    logic [CBW-1:0]  wcnt_q, wcnt_d;
    logic [CBW-1:0]  rcnt_q, rcnt_d;
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic [1:0]      full_q, full_d;
    logic [SW-1:0]   dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            dout_first_q, dout_first_d;

    logic [SW-1:0]   mem [2][N];
    logic [SW-1:0]   rd_data;
    logic [SW-1:0]   out_data;
    logic            wr_en;

    function automatic logic [CBW-1:0] bitrev(input logic [CBW-1:0] a);
        logic [CBW-1:0] r;
        for (int i = 0; i < CBW; i++) r[i] = a[CBW-1-i];
        return r;
    endfunction

    assign wr_en   = bus.din_valid && !clear;
    assign rd_data = mem[rbank_q][bitrev(rcnt_q)];

`ifdef FFT_BITREV_CONJ_EN
    logic [DBW-1:0] im;
    assign im = rd_data[DBW-1:0];

    // The most negative value has no positive twin, so it clamps to the max.
    always_comb begin
        out_data = rd_data;
        if (im == {1'b1, {(DBW-1){1'b0}}})
            out_data[DBW-1:0] = {1'b0, {(DBW-1){1'b1}}};
        else
            out_data[DBW-1:0] = -im;
    end
`else
    assign out_data = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wbank_q][wcnt_q] <= bus.din;
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        full_d       = full_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        dout_first_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            wcnt_d  = '0;
            rcnt_d  = '0;
            wbank_d = 1'b0;
            rbank_d = 1'b0;
            full_d  = '0;
        end else begin
            if (bus.din_valid) begin
                wcnt_d = wcnt_q + 1'b1;
                if (wcnt_q == {CBW{1'b1}}) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                end
            end
            // Banks are consumed in the order they filled, so rbank just alternates.
            case (state_q)
                IDLE: begin
                    if (full_q[rbank_q]) begin
                        state_d = READ;
                        rcnt_d  = '0;
                    end
                end
                READ: begin
                    dout_valid_d = 1'b1;
                    dout_first_d = (rcnt_q == '0);
                    dout_d       = out_data;
                    rcnt_d       = rcnt_q + 1'b1;
                    if (rcnt_q == {CBW{1'b1}}) begin
                        full_d[rbank_q] = 1'b0;
                        rbank_d         = ~rbank_q;
                        state_d         = full_q[~rbank_q] ? READ : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            full_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            full_q       <= full_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_first_q <= dout_first_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_first = dout_first_q;
endmodule
